// File: rtl/vram_pkg.sv
// Shared constants and types for the VGA pixel-RAM arbiter slice.
// Includes the RAM geometry, the read-sequencer state encoding and the scan-out address helper.
package vram_pkg;

    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_DATA_W = 24;
    localparam int ROW_W       = 9;
    localparam int COL_W       = 10;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rd_state_t;

    // Pixel address is the row/column concatenation, not row*H_ACTIVE+col.
    function automatic logic [VRAM_ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU bus port of the pixel-RAM arbiter.
// The CPU side uses the master modport; the arbiter uses the slave modport.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vram_wfifo.sv
// Posted-write FIFO of {addr, data}; pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr[IDX_W-1:0]] <= push_addr;
            data_mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr[IDX_W-1:0]];
    assign head_data = data_mem[rd_ptr[IDX_W-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port pixel RAM between VGA scan-out and a CPU port.
// Scan-out always wins the slot; posted writes then drain, then a pending read.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic              vga_rdn,
    input  logic [ROW_W-1:0]  vga_row,
    input  logic [COL_W-1:0]  vga_col,
    output logic [DATA_W-1:0] vga_data,
    vram_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rd_capture;
    logic              ready;
    logic              wr_acc;
    logic              rd_acc;
    logic              slot_vga;
    logic              slot_wr;
    logic              slot_rd;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready looks only at registered occupancy so a same-cycle pop never frees a slot.
    assign ready  = (state == IDLE) && (cpu.cpu_we ? !full : empty);
    assign wr_acc = cpu.cpu_req &  cpu.cpu_we & ready;
    assign rd_acc = cpu.cpu_req & ~cpu.cpu_we & ready;

    assign slot_vga = ~vga_rdn;
    assign slot_wr  = vga_rdn & ~empty;
    assign slot_rd  = vga_rdn & empty & (state == RD_WAIT);

    vram_wfifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_wfifo (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .push      (wr_acc),
        .push_addr (cpu.cpu_addr),
        .push_data (cpu.cpu_wdata),
        .pop       (slot_wr),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = head_data;
        if (slot_vga) begin
            mem_addr = ADDR_W'(pix_addr(vga_row, vga_col));
        end else if (slot_wr) begin
            mem_addr = head_addr;
            mem_we   = 1'b1;
        end else if (slot_rd) begin
            mem_addr = rd_addr;
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_acc)  state_nxt = RD_WAIT;
            RD_WAIT: if (slot_rd) state_nxt = RD_DONE;
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rvalid     = (state == RD_DONE);
        rd_capture = slot_rd;
    end

    always_ff @(posedge vga_clk) begin
        if (rd_acc) rd_addr <= cpu.cpu_addr;
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn)           rdata <= '0;
        else if (rd_capture) rdata <= mem_rdata;
    end

    assign vga_data       = mem_rdata;
    assign cpu.cpu_ready  = ready;
    assign cpu.cpu_rvalid = rvalid;
    assign cpu.cpu_rdata  = rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, directed corner sequences
// and a randomized run compared against a queue-based behavioural model.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = VRAM_ADDR_W;
    localparam int DW    = VRAM_DATA_W;
    localparam int RAM_N = 1 << AW;

    logic          vga_clk;
    logic          clrn;
    logic          vga_rdn;
    logic [8:0]    vga_row;
    logic [9:0]    vga_col;
    logic [DW-1:0] vga_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    vram_arbiter_if cpu_if ();

    vram_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .vga_rdn   (vga_rdn),
        .vga_row   (vga_row),
        .vga_col   (vga_col),
        .vga_data  (vga_data),
        .cpu       (cpu_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Physical RAM seen by the DUT and the model's own copy of memory contents.
    logic [DW-1:0] ram  [RAM_N];
    logic [DW-1:0] mram [RAM_N];
    assign mem_rdata = ram[mem_addr];

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    int            q_a[$];
    logic [DW-1:0] q_d[$];
    int            ph;
    int            m_raddr;
    logic [DW-1:0] m_rdata;
    bit            model_chk;

    // Per-cycle expectations and DUT snapshots
    logic          e_ready, e_we, e_rvalid, e_cap;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rdata, e_vdata;
    logic          s_ready, s_mwe, s_rvalid;
    logic [AW-1:0] s_maddr;
    logic [DW-1:0] s_mwdata, s_rdata, s_vdata;

    typedef struct {
        logic          rdn, req, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          x_ready, x_we;
        logic [AW-1:0] x_maddr;
        logic [DW-1:0] x_wd;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [DW-1:0] pat(input int a);
        logic [31:0] t;
        t = a * 32'h9E3779B1;
        return t[30:7];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q_a.delete();
        q_d.delete();
        ph      = 0;
        m_rdata = '0;
    endtask

    task automatic model_expect();
        int n;
        n        = q_a.size();
        e_ready  = (ph == 0) && (cpu_if.cpu_we ? (n < DEPTH) : (n == 0));
        e_we     = 1'b0;
        e_wd     = '0;
        e_cap    = 1'b0;
        e_addr   = '0;
        if (!vga_rdn) begin
            e_addr = AW'(int'(vga_row) * 1024 + int'(vga_col));
        end else if (n > 0) begin
            e_addr = AW'(q_a[0]);
            e_wd   = q_d[0];
            e_we   = 1'b1;
        end else if (ph == 1) begin
            e_addr = AW'(m_raddr);
            e_cap  = 1'b1;
        end
        e_rvalid = (ph == 2);
        e_rdata  = m_rdata;
        e_vdata  = mram[e_addr];
    endtask

    task automatic model_step();
        bit acc_w, acc_r;
        acc_w = cpu_if.cpu_req && cpu_if.cpu_we && e_ready;
        acc_r = cpu_if.cpu_req && !cpu_if.cpu_we && e_ready;
        if (e_we) begin
            mram[e_addr] = e_wd;
            void'(q_a.pop_front());
            void'(q_d.pop_front());
        end
        if (e_cap) m_rdata = mram[m_raddr];
        if (ph == 2)               ph = 0;
        else if (ph == 1 && e_cap) ph = 2;
        else if (ph == 0 && acc_r) begin
            ph      = 1;
            m_raddr = int'(cpu_if.cpu_addr);
        end
        if (acc_w) begin
            q_a.push_back(int'(cpu_if.cpu_addr));
            q_d.push_back(cpu_if.cpu_wdata);
        end
    endtask

    // One clock: sample at the falling edge, then advance RAM and model on the rising edge.
    task automatic cyc();
        @(negedge vga_clk);
        if (!clrn) model_reset();
        model_expect();
        s_ready  = cpu_if.cpu_ready;
        s_mwe    = mem_we;
        s_maddr  = mem_addr;
        s_mwdata = mem_wdata;
        s_rvalid = cpu_if.cpu_rvalid;
        s_rdata  = cpu_if.cpu_rdata;
        s_vdata  = vga_data;
        if (model_chk) begin
            chk("m_ready",  32'(s_ready),  32'(e_ready));
            chk("m_we",     32'(s_mwe),    32'(e_we));
            chk("m_addr",   32'(s_maddr),  32'(e_addr));
            if (e_we) chk("m_wdata", 32'(s_mwdata), 32'(e_wd));
            chk("m_rvalid", 32'(s_rvalid), 32'(e_rvalid));
            chk("m_rdata",  32'(s_rdata),  32'(e_rdata));
            chk("m_vdata",  32'(s_vdata),  32'(e_vdata));
        end
        @(posedge vga_clk);
        if (s_mwe) ram[s_maddr] = s_mwdata;
        if (!clrn) model_reset();
        else       model_step();
        #1;
    endtask

    task automatic drive(input logic rdn, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        vga_rdn          = rdn;
        cpu_if.cpu_req   = req;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = d;
    endtask

    initial begin
        int run;
        logic [AW-1:0] exp_a;

        for (int i = 0; i < RAM_N; i++) begin
            ram[i]  = pat(i);
            mram[i] = pat(i);
        end
        model_reset();
        model_chk = 1'b1;
        clrn    = 1'b1;
        vga_row = 9'd3;
        vga_col = 10'd7;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #2 clrn = 1'b0;

        // Reset state
        cyc();
        chk("rst_ready",  32'(s_ready),  32'd1);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_we",     32'(s_mwe),    32'd0);
        chk("rst_rdata",  32'(s_rdata),  32'd0);
        cyc();
        clrn = 1'b1;
        cyc();

        // Single posted write, then FIFO fill under scan-out and drain
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 19'h00005, 24'hFF0000, 1'b1, 1'b0, 19'h00000, 24'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b0, 1'b1, 19'h00005, 24'hFF0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b1, 1'b0, 19'h00000, 24'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 19'h00010, 24'h0000A1, 1'b1, 1'b0, 19'h00C07, 24'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 19'h00011, 24'h0000A2, 1'b1, 1'b0, 19'h00C07, 24'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 19'h00012, 24'h0000A3, 1'b1, 1'b0, 19'h00C07, 24'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 19'h00013, 24'h0000A4, 1'b1, 1'b0, 19'h00C07, 24'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 19'h00014, 24'h0000A5, 1'b0, 1'b0, 19'h00C07, 24'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 19'h00014, 24'h0000A5, 1'b0, 1'b0, 19'h00C07, 24'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 19'h00014, 24'h0000A5, 1'b0, 1'b1, 19'h00010, 24'h0000A1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 19'h00014, 24'h0000A5, 1'b1, 1'b1, 19'h00011, 24'h0000A2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b0, 1'b1, 19'h00012, 24'h0000A3};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b0, 1'b1, 19'h00013, 24'h0000A4};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b0, 1'b1, 19'h00014, 24'h0000A5};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 19'h00000, 24'h000000, 1'b1, 1'b0, 19'h00000, 24'h0};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rdn, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wd);
            cyc();
            chk($sformatf("t%0d_ready", i), 32'(s_ready), 32'(tbl[i].x_ready));
            chk($sformatf("t%0d_we", i),    32'(s_mwe),   32'(tbl[i].x_we));
            chk($sformatf("t%0d_addr", i),  32'(s_maddr), 32'(tbl[i].x_maddr));
            if (tbl[i].x_we) chk($sformatf("t%0d_wdata", i), 32'(s_mwdata), 32'(tbl[i].x_wd));
            chk($sformatf("t%0d_rvalid", i), 32'(s_rvalid), 32'd0);
        end

        // Read-after-write: read waits for the drain, then returns the new data
        drive(1'b1, 1'b1, 1'b1, 19'h12345, 24'h123456);
        cyc();
        chk("raw_wr_ready", 32'(s_ready), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 19'h12345, 24'h0);
        cyc();
        chk("raw_rd_blocked", 32'(s_ready), 32'd0);
        chk("raw_drain_we",   32'(s_mwe),   32'd1);
        chk("raw_drain_addr", 32'(s_maddr), 32'h12345);
        cyc();
        chk("raw_rd_ready", 32'(s_ready), 32'd1);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        cyc();
        chk("raw_slot_addr", 32'(s_maddr),  32'h12345);
        chk("raw_slot_we",   32'(s_mwe),    32'd0);
        chk("raw_early",     32'(s_rvalid), 32'd0);
        cyc();
        chk("raw_rvalid", 32'(s_rvalid), 32'd1);
        chk("raw_rdata",  32'(s_rdata),  32'h123456);
        cyc();
        chk("raw_pulse",  32'(s_rvalid), 32'd0);
        chk("raw_hold",   32'(s_rdata),  32'h123456);

        // Read stalled by 20 cycles of scan-out
        drive(1'b0, 1'b1, 1'b0, 19'h0ABCD, '0);
        cyc();
        chk("stall_accept", 32'(s_ready), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) begin
            vga_row = 9'($urandom_range(0, V_ACTIVE - 1));
            vga_col = 10'($urandom_range(0, H_ACTIVE - 1));
            exp_a   = AW'(int'(vga_row) * 1024 + int'(vga_col));
            cyc();
            chk($sformatf("stall%0d_addr", i),   32'(s_maddr),  32'(exp_a));
            chk($sformatf("stall%0d_rvalid", i), 32'(s_rvalid), 32'd0);
        end
        vga_rdn = 1'b1;
        cyc();
        chk("stall_slot", 32'(s_maddr), 32'h0ABCD);
        cyc();
        chk("stall_rvalid", 32'(s_rvalid), 32'd1);
        chk("stall_rdata",  32'(s_rdata),  32'(pat(32'h0ABCD)));

        // Reset with two writes queued and a read held at the port
        drive(1'b0, 1'b1, 1'b1, 19'h00021, 24'hBEEF01);
        cyc();
        drive(1'b0, 1'b1, 1'b1, 19'h00022, 24'hBEEF02);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 19'h00021, '0);
        cyc();
        chk("rstq_rd_blocked", 32'(s_ready), 32'd0);
        clrn = 1'b0;
        cyc();
        chk("rstq_ready",  32'(s_ready),  32'd1);
        chk("rstq_rvalid", 32'(s_rvalid), 32'd0);
        chk("rstq_we",     32'(s_mwe),    32'd0);
        chk("rstq_rdata",  32'(s_rdata),  32'd0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rstq%0d_we", i),     32'(s_mwe),    32'd0);
            chk($sformatf("rstq%0d_rvalid", i), 32'(s_rvalid), 32'd0);
            chk($sformatf("rstq%0d_empty", i),  32'(s_ready),  32'd1);
        end

        // Reset while an accepted read waits for its slot
        drive(1'b0, 1'b1, 1'b0, 19'h12345, '0);
        cyc();
        chk("rstr_accept", 32'(s_ready), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cyc();
        clrn = 1'b0;
        cyc();
        clrn = 1'b1;
        vga_rdn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rstr%0d_rvalid", i), 32'(s_rvalid), 32'd0);
            chk($sformatf("rstr%0d_addr", i),   32'(s_maddr),  32'd0);
        end

        // Randomized traffic against the model
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                vga_rdn = ~vga_rdn;
                run = $urandom_range(1, 12);
            end
            run--;
            vga_row = 9'($urandom_range(0, 511));
            vga_col = 10'($urandom_range(0, 1023));
            if (!(cpu_if.cpu_req && !s_ready)) begin
                cpu_if.cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_if.cpu_we    = $urandom_range(0, 1) == 1;
                cpu_if.cpu_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                cpu_if.cpu_wdata = DW'($urandom);
            end
            cyc();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
